// File: rtl/dmem_rmw_ctrl.sv
// Data-memory controller for a word-wide SRAM without byte enables.
// Word stores and loads take one cycle; byte/halfword stores use a one-stall read-modify-write.
module dmem_rmw_ctrl #(
    parameter int P_DATA_WIDTH      = 32,
    parameter int P_DMEM_ADDR_WIDTH = 11
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_req,
    input  logic                         i_we,
    input  logic [P_DMEM_ADDR_WIDTH-1:0] i_addr,
    input  logic [P_DATA_WIDTH-1:0]      i_wdata,
    input  logic [1:0]                   i_storetype,
    output logic [P_DATA_WIDTH-1:0]      o_rdata,
    output logic                         o_stall,
    output logic                         o_misaligned,
    output logic                         o_sram_en,
    output logic                         o_sram_we,
    output logic [P_DMEM_ADDR_WIDTH-3:0] o_sram_addr,
    output logic [P_DATA_WIDTH-1:0]      o_sram_wdata,
    input  logic [P_DATA_WIDTH-1:0]      i_sram_rdata
);
    localparam int AW = P_DMEM_ADDR_WIDTH - 2;

    localparam logic [1:0] ST_SW = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SB = 2'b10;

    // Core handshake: i_req is a valid that the core holds stable while o_stall is high;
    // the request is consumed at the first rising edge where o_stall is low.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_MERGE = 1'b1
    } state_t;

    state_t          state, next_state;
    logic [AW-1:0]   lat_addr;
    logic [1:0]      lat_off;
    logic            lat_sb;
    logic [15:0]     lat_wdata;
    logic            req_act;
    logic            sw_ok;
    logic            part_ok;
    logic            store_bad;
    logic [P_DATA_WIDTH-1:0] merged;

    // Requests are masked while reset is held so nothing reaches the SRAM.
    assign req_act   = i_req & i_rst_n;
    assign sw_ok     = (i_storetype == ST_SW) && (i_addr[1:0] == 2'b00);
    assign part_ok   = ((i_storetype == ST_SH) && !i_addr[0]) || (i_storetype == ST_SB);
    assign store_bad = (state == S_IDLE) && req_act && i_we && !sw_ok && !part_ok;
    assign o_rdata   = i_sram_rdata;

    always_comb begin
        merged = i_sram_rdata;
        if (lat_sb) begin
            merged[{lat_off, 3'b000} +: 8] = lat_wdata[7:0];
        end else begin
            merged[{lat_off[1], 4'b0000} +: 16] = lat_wdata;
        end
    end

    always_comb begin
        next_state   = state;
        o_sram_en    = 1'b0;
        o_sram_we    = 1'b0;
        o_sram_addr  = i_addr[P_DMEM_ADDR_WIDTH-1:2];
        o_sram_wdata = i_wdata;
        o_stall      = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_act) begin
                    if (!i_we) begin
                        o_sram_en = 1'b1;
                    end else if (sw_ok) begin
                        o_sram_en = 1'b1;
                        o_sram_we = 1'b1;
                    end else if (part_ok) begin
                        o_sram_en  = 1'b1;
                        o_stall    = 1'b1;
                        next_state = S_MERGE;
                    end
                end
            end
            S_MERGE: begin
                // The core is still presenting the stalled request; it is not re-decoded.
                o_sram_en    = 1'b1;
                o_sram_we    = 1'b1;
                o_sram_addr  = lat_addr;
                o_sram_wdata = merged;
                next_state   = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            lat_addr     <= '0;
            lat_off      <= '0;
            lat_sb       <= 1'b0;
            lat_wdata    <= '0;
            o_misaligned <= 1'b0;
        end else begin
            state        <= next_state;
            o_misaligned <= store_bad;
            if ((state == S_IDLE) && req_act && i_we && !sw_ok && part_ok) begin
                lat_addr  <= i_addr[P_DMEM_ADDR_WIDTH-1:2];
                lat_off   <= i_addr[1:0];
                lat_sb    <= (i_storetype == ST_SB);
                lat_wdata <= i_wdata[15:0];
            end
        end
    end
endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Bench for dmem_rmw_ctrl: SRAM model, directed scenarios plus random traffic,
// scoreboarded against a word-array reference memory.
module tb_dmem_rmw_ctrl;
    logic        i_clk;
    logic        i_rst_n;
    logic        i_req;
    logic        i_we;
    logic [10:0] i_addr;
    logic [31:0] i_wdata;
    logic [1:0]  i_storetype;
    logic [31:0] o_rdata;
    logic        o_stall;
    logic        o_misaligned;
    logic        o_sram_en;
    logic        o_sram_we;
    logic [8:0]  o_sram_addr;
    logic [31:0] o_sram_wdata;
    logic [31:0] i_sram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sram_mem [0:511];
    logic [31:0] ref_mem  [0:511];
    logic [31:0] exp_q  [$];
    logic [40:0] exp_wq [$];

    dmem_rmw_ctrl #(.P_DATA_WIDTH(32), .P_DMEM_ADDR_WIDTH(11)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_we(i_we),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_storetype(i_storetype),
        .o_rdata(o_rdata), .o_stall(o_stall), .o_misaligned(o_misaligned),
        .o_sram_en(o_sram_en), .o_sram_we(o_sram_we), .o_sram_addr(o_sram_addr),
        .o_sram_wdata(o_sram_wdata), .i_sram_rdata(i_sram_rdata)
    );

    // clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    // SRAM model: synchronous, read data valid one cycle after the read
    always @(posedge i_clk) begin
        if (o_sram_en) begin
            if (o_sram_we) sram_mem[o_sram_addr] <= o_sram_wdata;
            else           i_sram_rdata <= sram_mem[o_sram_addr];
        end
    end

    task automatic chk(input string name, input logic [40:0] act, input logic [40:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=%h req=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // monitor: load data and SRAM writes
    logic load_pend = 1'b0;
    always @(negedge i_clk) begin
        if (load_pend) begin
            if (exp_q.size() == 0) chk("rdata_unexpected", 41'(o_rdata), 41'h1_0000_0000);
            else                   chk("rdata", 41'(o_rdata), 41'(exp_q.pop_front()));
        end
        load_pend = i_rst_n && o_sram_en && !o_sram_we && !o_stall;
        if (o_sram_en && o_sram_we) begin
            if (exp_wq.size() == 0) chk("write_unexpected", {o_sram_addr, o_sram_wdata}, '1);
            else                    chk("write", {o_sram_addr, o_sram_wdata}, exp_wq.pop_front());
        end
    end

    task automatic preload(input logic [8:0] w, input logic [31:0] v);
        sram_mem[w] = v;
        ref_mem[w]  = v;
    endtask

    // driver: called just after a rising edge; returns just after a later rising edge
    task automatic op(input logic we, input logic [10:0] addr, input logic [31:0] wdata,
                      input logic [1:0] st);
        logic [8:0]  w;
        logic [31:0] mask, lane, nv;
        int          sh;
        logic        exp_stall, exp_mis;
        w = addr[10:2];
        exp_stall = 1'b0;
        exp_mis   = 1'b0;
        if (!we) begin
            exp_q.push_back(ref_mem[w]);
        end else if (st == 2'd0 && addr[1:0] == 2'd0) begin
            ref_mem[w] = wdata;
            exp_wq.push_back({w, wdata});
        end else if ((st == 2'd1 && !addr[0]) || st == 2'd2) begin
            if (st == 2'd2) begin
                sh = 8 * int'(addr[1:0]);
                mask = 32'hFF << sh;
                lane = (wdata & 32'hFF) << sh;
            end else begin
                sh = 16 * int'(addr[1]);
                mask = 32'hFFFF << sh;
                lane = (wdata & 32'hFFFF) << sh;
            end
            nv = (ref_mem[w] & ~mask) | lane;
            ref_mem[w] = nv;
            exp_wq.push_back({w, nv});
            exp_stall = 1'b1;
        end else begin
            exp_mis = 1'b1;
        end
        i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wdata; i_storetype = st;
        @(negedge i_clk);
        chk("stall_first", 41'(o_stall), 41'(exp_stall));
        if (exp_stall) begin
            @(posedge i_clk); #1;
            @(negedge i_clk);
            chk("stall_merge", 41'(o_stall), 41'(1'b0));
        end
        @(posedge i_clk); #1;
        i_req = 1'b0;
        chk("misaligned", 41'(o_misaligned), 41'(exp_mis));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk); #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        i_rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0; i_storetype = '0;
        #23;
        chk("rst_stall", 41'(o_stall), 41'(1'b0));
        chk("rst_mis", 41'(o_misaligned), 41'(1'b0));
        chk("rst_en", 41'(o_sram_en), 41'(1'b0));
        @(negedge i_clk) i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // word store then load
        op(1'b1, 11'h010, 32'hDEADBEEF, 2'd0);
        op(1'b0, 11'h010, 32'h0, 2'd0);
        idle(1);
        // byte store, halfword store
        preload(9'h004, 32'h11223344);
        op(1'b1, 11'h012, 32'h000000AA, 2'd2);
        op(1'b0, 11'h010, 32'h0, 2'd0);
        preload(9'h004, 32'h11223344);
        op(1'b1, 11'h012, 32'h0000BEEF, 2'd1);
        op(1'b0, 11'h010, 32'h0, 2'd0);
        // misaligned stores and illegal type
        op(1'b1, 11'h011, 32'h12345678, 2'd0);
        op(1'b1, 11'h013, 32'h0000ABCD, 2'd1);
        op(1'b1, 11'h010, 32'h0000ABCD, 2'd3);
        op(1'b0, 11'h011, 32'h0, 2'd3);
        idle(1);
        chk("mis_clears", 41'(o_misaligned), 41'(1'b0));
        op(1'b0, 11'h010, 32'h0, 2'd0);
        // back-to-back byte stores
        preload(9'h004, 32'h0);
        op(1'b1, 11'h010, 32'h00000055, 2'd2);
        op(1'b1, 11'h011, 32'h00000066, 2'd2);
        op(1'b0, 11'h010, 32'h0, 2'd0);
        idle(1);

        // reset during MERGE
        preload(9'h006, 32'hCAFEF00D);
        i_req = 1'b1; i_we = 1'b1; i_addr = 11'h019; i_wdata = 32'h77; i_storetype = 2'd2;
        @(negedge i_clk);
        chk("rstm_stall0", 41'(o_stall), 41'(1'b1));
        @(posedge i_clk); #1;
        i_rst_n = 1'b0; i_req = 1'b0;
        #1;
        chk("rstm_we", 41'(o_sram_we), 41'(1'b0));
        chk("rstm_stall", 41'(o_stall), 41'(1'b0));
        @(negedge i_clk) i_rst_n = 1'b1;
        #1;
        chk("rstm_idle", 41'(o_sram_en), 41'(1'b0));
        @(posedge i_clk); #1;
        op(1'b0, 11'h018, 32'h0, 2'd0);

        // random traffic over a small window so words collide
        for (int i = 0; i < 300; i++) begin
            op(1'($urandom_range(0, 1)), 11'($urandom_range(0, 31)), $urandom,
               2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        for (int i = 0; i < 8; i++) op(1'b0, 11'(i * 4), 32'h0, 2'd0);

        idle(3);
        chk("exp_q_drained", 41'(exp_q.size()), 41'd0);
        chk("exp_wq_drained", 41'(exp_wq.size()), 41'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
